// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes, frame helper.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  typedef logic [9:0] ps2_frame_t;

  // {stop, odd parity, d7..d0}; bits leave LSB first.
  function automatic ps2_frame_t ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Pad-input synchroniser for the PS/2 clock and data lines, plus falling-edge detect on the clock.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Idle lines are pulled high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s_o    = clk_sync_q[SYNC_STAGES-1];
  assign data_s_o   = data_sync_q[SYNC_STAGES-1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command frame open-drain, checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_TIMEOUT    = 750000,
  parameter int PKT_TIMEOUT    = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic       busy_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drive_low_o,
  output logic       ps2_data_drive_low_o
);

  localparam int         CNT_MAX   = (REQ_TIMEOUT > PKT_TIMEOUT) ? REQ_TIMEOUT : PKT_TIMEOUT;
  localparam int         CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [3:0] LAST_FALL = 4'd10;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ps2_frame_t       frame_q, frame_d;
  logic [3:0]       idx_q, idx_d;
  logic             clk_drv_q, clk_drv_d;
  logic             data_drv_q, data_drv_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             clk_s, data_s, clk_fall_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             pkt_to_s;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .clk_fall_o (clk_fall_s)
  );

  assign cnt_inc_s = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign pkt_to_s  = (cnt_q == CNT_W'(PKT_TIMEOUT - 1));

  // Next-state logic; data drive is only updated on a detected fall, i.e. while the clock is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc_s;
    frame_d    = frame_q;
    idx_d      = idx_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_valid_i && tx_ready_o) begin
          frame_d   = ps2_frame(tx_data_i);
          idx_d     = 4'd0;
          clk_drv_d = 1'b1;
          state_d   = ST_INHIBIT;
        end else begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          clk_drv_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end else if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) begin
          data_drv_d = 1'b1;
        end else begin
          data_drv_d = data_drv_q;
        end
      end
      ST_REQ: begin
        if (clk_fall_s) begin
          data_drv_d = ~frame_q[0];
          idx_d      = 4'd1;
          cnt_d      = '0;
          state_d    = ST_SEND;
        end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SEND: begin
        if (pkt_to_s) begin
          state_d = ST_FAIL;
        end else if (clk_fall_s) begin
          if (idx_q == LAST_FALL) begin
            state_d = ST_ACK;
          end else begin
            data_drv_d = ~frame_q[idx_q];
            idx_d      = idx_q + 4'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ACK: begin
        if (pkt_to_s || data_s) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (pkt_to_s) begin
          state_d = ST_FAIL;
        end else if (clk_s && data_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
      end
    endcase
    // The error pulse is the single FAIL cycle; both lines are already released by then.
    if (state_d == ST_FAIL) begin
      clk_drv_d  = 1'b0;
      data_drv_d = 1'b0;
    end else begin
      clk_drv_d  = clk_drv_d;
    end
    error_d = (state_d == ST_FAIL);
    done_d  = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE);
  end

  // State, counter, frame and registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      idx_q      <= 4'd0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Ready is held off during the done cycle so a new request lands after the pulse.
  assign tx_ready_o           = (state_q == ST_IDLE) && !done_q;
  assign busy_o               = (state_q != ST_IDLE);
  assign tx_done_o            = done_q;
  assign tx_error_o           = error_q;
  assign ps2_clk_drive_low_o  = clk_drv_q;
  assign ps2_data_drive_low_o = data_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models the keyboard on open-drain pads and scores captured frames and pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int REQT = 400;
  localparam int PKTT = 2000;
  localparam int HALF = 20;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_RESET  = 2;
  localparam int M_SILENT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       clk_drv, data_drv;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pad, ps2_data_pad;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int acc_cnt     = 0;
  int overlap_cnt = 0;

  logic [9:0] exp_q[$];

  assign ps2_clk_pad  = ~(clk_drv | dev_clk_low);
  assign ps2_data_pad = ~(data_drv | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_TIMEOUT    (REQT),
    .PKT_TIMEOUT    (PKTT),
    .SYNC_STAGES    (2)
  ) dut (
    .clock_i              (clk),
    .reset_i              (reset),
    .tx_valid_i           (tx_valid),
    .tx_data_i            (tx_data),
    .tx_ready_o           (tx_ready),
    .tx_done_o            (tx_done),
    .tx_error_o           (tx_error),
    .busy_o               (busy),
    .ps2_clk_i            (ps2_clk_pad),
    .ps2_data_i           (ps2_data_pad),
    .ps2_clk_drive_low_o  (clk_drv),
    .ps2_data_drive_low_o (data_drv)
  );

  always @(posedge clk) begin
    if (!reset) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt <= err_cnt + 1;
      if (tx_done && tx_error) overlap_cnt <= overlap_cnt + 1;
      if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge clk);
    check("ready_idle", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back({1'b1, ~^d, d});
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic device_xfer(input int mode);
    int n;
    int w;
    int d0;
    int e0;
    bit aborted;
    logic [9:0] cap;
    logic [9:0] exp;
    d0      = done_cnt;
    e0      = err_cnt;
    aborted = 1'b0;
    cap     = '0;
    w = 0;
    while (!clk_drv && w < 20) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (clk_drv && n < INH + 50) begin
      @(negedge clk);
      if (clk_drv) n++;
    end
    check("inhibit_len", 32'((n >= INH - 1) && (n <= INH + 1)), 32'd1);
    check("start_bit", 32'(ps2_data_pad), 32'd0);
    check("busy_xfer", 32'(busy), 32'd1);
    if (mode == M_SILENT) begin
      n = 0;
      while (!tx_error && n < REQT + 100) begin
        @(negedge clk);
        n++;
      end
      check("req_timeout", 32'(n), 32'(REQT));
      check("drives_at_err", 32'({clk_drv, data_drv}), 32'd0);
    end else begin
      repeat (30) @(negedge clk);
      for (int f = 1; f <= 11; f++) begin
        if (f == 11 && mode != M_NOACK) begin
          dev_data_low = 1'b1;
          repeat (2) @(negedge clk);
        end
        @(negedge clk);
        dev_clk_low = 1'b1;
        if (mode == M_RESET && f == 5) begin
          reset = 1'b1;
          @(posedge clk);
          #1;
          check("rst_drives", 32'({clk_drv, data_drv}), 32'd0);
          check("rst_ready", 32'(tx_ready), 32'd1);
          check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
          @(negedge clk);
          reset        = 1'b0;
          dev_clk_low  = 1'b0;
          dev_data_low = 1'b0;
          aborted      = 1'b1;
          break;
        end
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        if (f <= 10) cap[f-1] = ps2_data_pad;
        repeat (HALF / 2 - 1) @(negedge clk);
      end
      if (!aborted) begin
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    if (!aborted && mode != M_SILENT) check("frame", 32'(cap), 32'(exp));
    n = 0;
    while (!aborted && !(tx_done || tx_error) && n < 300 && mode == M_ACK) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), (mode == M_ACK) ? 32'd1 : 32'd0);
    check("err_count", 32'(err_cnt - e0), (mode == M_NOACK || mode == M_SILENT) ? 32'd1 : 32'd0);
    check("ready_after", 32'(tx_ready), 32'd1);
    check("idle_drives", 32'({busy, clk_drv, data_drv}), 32'd0);
  endtask

  initial begin
    int a0;
    reset        = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({tx_done, tx_error}), 32'd0);
    check("reset_drives", 32'({clk_drv, data_drv}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send(PS2_CMD_SET_LEDS, 1'b0); device_xfer(M_ACK);
    send(8'h01, 1'b0);            device_xfer(M_ACK);
    send(PS2_CMD_RESET, 1'b0);    device_xfer(M_ACK);
    send(PS2_CMD_SET_LEDS, 1'b0); device_xfer(M_SILENT);
    send(PS2_CMD_RESET, 1'b0);    device_xfer(M_NOACK);
    send(PS2_CMD_SET_LEDS, 1'b0); device_xfer(M_RESET);
    send(PS2_CMD_ENABLE, 1'b0);   device_xfer(M_ACK);

    a0 = acc_cnt;
    send(8'hA5, 1'b1);
    device_xfer(M_ACK);
    repeat (50) @(negedge clk);
    check("held_valid_accepts", 32'(acc_cnt - a0), 32'd1);
    check("held_valid_idle", 32'({busy, clk_drv}), 32'd0);

    check("done_err_overlap", 32'(overlap_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
